// File: rtl/mvm_pkg.sv
// mvm_pkg: shared sizes, counter widths and FSM states for the matrix-vector multiplier
package mvm_pkg;
  localparam int M = 16;
  localparam int N = 16;
  localparam int T = 8;
  localparam int OUT_W = 2 * T;
  localparam int MN = M * N;
  localparam int MN_W = $clog2(MN);
  localparam int CNT_W = $clog2(MN + 2);
  localparam int ROW_W = $clog2(M);
  localparam int COL_W = $clog2(N);
  localparam logic signed [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_X, COMPUTE, DONE, STREAM} state_t;
endpackage

// File: rtl/mvm_mac.sv
// mvm_mac: signed TxT multiply into a 2T accumulator (saturating when MVM_SAT_EN is defined)
// Ports: clk, reset (async active-low), clr (restart sum with this product), en, a, b, acc.
module mvm_mac
  import mvm_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [T-1:0]     a,
  input  logic signed [T-1:0]     b,
  output logic signed [OUT_W-1:0] acc
);
  logic signed [OUT_W-1:0] prod, base, sum;
  assign prod = OUT_W'(a) * OUT_W'(b);
  assign base = clr ? '0 : acc;
`ifdef MVM_SAT_EN
  logic signed [OUT_W:0] wide;
  assign wide = {base[OUT_W-1], base} + {prod[OUT_W-1], prod};
  // overflow shows up as disagreement between the guard bit and the sign bit
  assign sum = (wide[OUT_W] != wide[OUT_W-1]) ? (wide[OUT_W] ? SAT_MIN : SAT_MAX) : wide[OUT_W-1:0];
`else
  assign sum = base + prod;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) acc <= '0;
    else if (en) acc <= sum;
endmodule

// File: rtl/mvm_16_16_8_1.sv
// mvm_16_16_8_1: serial-load 16x16 signed matrix-vector multiplier with one MAC lane
// Ports: clk, reset (async active-low), loadMatrix/loadVector/start command pulses,
//        data_in (T-bit element), done (one-cycle pulse before streaming), data_out (2T-bit y).
// Build option: define MVM_SAT_EN for a saturating accumulator; default wraps.
module mvm_16_16_8_1
  import mvm_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    loadMatrix,
  input  logic                    loadVector,
  input  logic                    start,
  input  logic signed [T-1:0]     data_in,
  output logic                    done,
  output logic signed [OUT_W-1:0] data_out
);
  state_t state, nxt;
  logic [CNT_W-1:0] k;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row, wr_row;
  logic wr, mac_en;
  logic signed [T-1:0] a_mem [MN];
  logic signed [T-1:0] x_mem [N];
  logic signed [OUT_W-1:0] y_buf [M];
  logic signed [OUT_W-1:0] acc;
  assign col = k[COL_W-1:0];
  assign row = k[COL_W +: ROW_W];
  // k runs two counts past the last MAC so the final row is written back before DONE
  assign mac_en = state == COMPUTE && k < CNT_W'(MN);
  assign done = state == DONE;
  mvm_mac u_mac (
    .clk    (clk),
    .reset  (reset),
    .clr    (col == '0),
    .en     (mac_en),
    .a      (a_mem[k[MN_W-1:0]]),
    .b      (x_mem[col]),
    .acc    (acc)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = loadMatrix ? LOAD_A : loadVector ? LOAD_X : start ? COMPUTE : IDLE;
      LOAD_A:  nxt = (k == CNT_W'(MN - 1)) ? IDLE : LOAD_A;
      LOAD_X:  nxt = (k == CNT_W'(N - 1)) ? IDLE : LOAD_X;
      COMPUTE: nxt = (k == CNT_W'(MN + 1)) ? DONE : COMPUTE;
      DONE:    nxt = STREAM;
      STREAM:  nxt = (k == CNT_W'(M - 1)) ? IDLE : STREAM;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      k <= '0;
      wr <= 1'b0;
      wr_row <= '0;
      data_out <= '0;
    end else begin
      state <= nxt;
      // DONE emits y[0] itself, so STREAM resumes counting at 1
      k <= (state == IDLE || nxt != state) ? CNT_W'(state == DONE) : k + CNT_W'(1);
      wr <= mac_en && col == COL_W'(N - 1);
      wr_row <= row;
      if (state == DONE || state == STREAM) data_out <= y_buf[k[ROW_W-1:0]];
    end
  end
  // storage has no reset so operands survive an aborted load
  always_ff @(posedge clk) begin
    if (state == LOAD_A) a_mem[k[MN_W-1:0]] <= data_in;
    if (state == LOAD_X) x_mem[col] <= data_in;
    if (wr) y_buf[wr_row] <= acc;
  end
endmodule

// File: tb/tb_mvm_16_16_8_1.sv
// tb_mvm_16_16_8_1: directed and random checks of loading, compute latency, streaming and reset
module tb_mvm_16_16_8_1;
  typedef logic signed [15:0] vec_t [16];
  logic clk = 0, reset = 0, loadMatrix = 0, loadVector = 0, start = 0, done;
  logic signed [7:0] data_in = 0;
  logic signed [15:0] data_out;
  logic signed [7:0] av [256];
  logic signed [7:0] xv [16];
  logic signed [7:0] am [256];
  logic signed [7:0] xm [16];
  vec_t ev;
  int tests = 0, fails = 0, done_cnt = 0, d0;
  always #5 clk = ~clk;
  always @(negedge clk) if (done) done_cnt++;
  mvm_16_16_8_1 dut (
    .clk        (clk),
    .reset      (reset),
    .loadMatrix (loadMatrix),
    .loadVector (loadVector),
    .start      (start),
    .done       (done),
    .data_in    (data_in),
    .data_out   (data_out)
  );
  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic vec_t model();
    vec_t y;
    for (int r = 0; r < 16; r++) begin
      y[r] = 0;
      for (int c = 0; c < 16; c++) y[r] = y[r] + am[r*16+c] * xm[c];
    end
    return y;
  endfunction
  task automatic load_a(input int n, input bit with_start);
    @(posedge clk); #1 loadMatrix = 1; start = with_start;
    @(posedge clk); #1 loadMatrix = 0; start = 0;
    for (int i = 0; i < n; i++) begin
      data_in = av[i];
      @(posedge clk); #1 am[i] = av[i];
    end
  endtask
  task automatic load_x();
    @(posedge clk); #1 loadVector = 1;
    @(posedge clk); #1 loadVector = 0;
    for (int i = 0; i < 16; i++) begin
      data_in = xv[i];
      @(posedge clk); #1 xm[i] = xv[i];
    end
  endtask
  task automatic run(input string tag, input vec_t e, input bit mid);
    int base, lat;
    base = done_cnt;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    lat = 0;
    while (!done && lat < 400) begin
      @(posedge clk); lat++;
      #1 start = mid && lat == 50;
    end
    start = 0;
    check({tag, "_latency"}, lat, 258);
    for (int r = 0; r < 16; r++) begin
      @(posedge clk); #1 check($sformatf("%s_y%0d", tag, r), data_out, e[r]);
    end
    @(posedge clk); #1 check({tag, "_hold"}, data_out, e[15]);
    check({tag, "_done_pulses"}, done_cnt - base, 1);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 check("reset_done", done, 0);
    check("reset_data_out", data_out, 0);
    reset = 1;
    for (int i = 0; i < 256; i++) av[i] = (i / 16 == i % 16) ? 8'sd1 : 8'sd0;
    load_a(256, 0);
    for (int c = 0; c < 16; c++) xv[c] = 8'(c - 8);
    load_x();
    for (int r = 0; r < 16; r++) ev[r] = 16'(r - 8);
    run("identity", ev, 0);
    for (int i = 0; i < 256; i++) av[i] = 1;
    for (int c = 0; c < 16; c++) xv[c] = 3;
    load_a(256, 0);
    load_x();
    for (int r = 0; r < 16; r++) ev[r] = 48;
    run("ones", ev, 0);
    for (int i = 0; i < 256; i++) av[i] = -1;
    load_a(256, 0);
    for (int r = 0; r < 16; r++) ev[r] = -48;
    run("neg_ones", ev, 0);
    for (int i = 0; i < 256; i++) av[i] = 8'(i % 7 - 3);
    for (int c = 0; c < 16; c++) xv[c] = 8'(5 - c);
    load_a(256, 0);
    load_x();
    ev = model();
    run("reuse1", ev, 0);
    run("reuse2", ev, 0);
    for (int c = 0; c < 16; c++) xv[c] = 8'(2 * c - 15);
    load_x();
    ev = model();
    run("reload_x", ev, 0);
    for (int i = 0; i < 256; i++) av[i] = 8'((i * 5) % 31 - 15);
    load_a(100, 0);
    reset = 0;
    #1 check("midload_reset_data_out", data_out, 0);
    check("midload_reset_done", done, 0);
    #2 reset = 1;
    d0 = done_cnt;
    repeat (20) @(posedge clk);
    #1 check("midload_no_early_done", done_cnt, d0);
    ev = model();
    run("midload", ev, 0);
    for (int i = 0; i < 256; i++) av[i] = 8'(i % 9 - 4);
    d0 = done_cnt;
    load_a(256, 1);
    repeat (280) @(posedge clk);
    #1 check("priority_no_done", done_cnt, d0);
    ev = model();
    run("priority", ev, 1);
    for (int n = 0; n < 6; n++) begin
      int op;
      op = int'($urandom_range(0, 2));
      if (op != 1) begin
        for (int i = 0; i < 256; i++) av[i] = 8'(int'($urandom_range(0, 62)) - 31);
        load_a(256, 0);
      end
      if (op != 0) begin
        for (int c = 0; c < 16; c++) xv[c] = 8'(int'($urandom_range(0, 62)) - 31);
        load_x();
      end
      ev = model();
      run($sformatf("random%0d", n), ev, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
